pc_fetch_sequencer: RTL

PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pc_fetch_sequencer.sv | 75 +++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, flag_type codes and halt word.
// Used by pc_fetch_sequencer and pc_displacement so both agree on jump/branch decoding.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_HALT   = 2'd3
    } seq_state_t;

    localparam logic [3:0]  FT_JUMP            = 4'b1000;
    localparam logic [3:0]  FT_BRANCH          = 4'b1100;
    localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;

    // dis_in is only defined by the displacement stage for these two encodings
    function automatic logic takes_target(input logic [3:0] ft);
        return (ft == FT_JUMP) || (ft == FT_BRANCH);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Fetch/execute/update sequencer: owns the PC and IR, drives instruction memory reads.
// Latency: 3 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: fetch stalls in FETCH while en or instr_valid is low; HALT is terminal until reset.
module pc_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        instr_valid,
    input  logic [15:0] instr_rdata,
    input  logic [15:0] dis_in,
    output logic        instr_req,
    output logic [15:0] instr_addr,
    output logic [15:0] pc_out,
    output logic [15:0] ir_out,
    output logic [3:0]  flag_type,
    output logic [3:0]  condition,
    output logic [15:0] imm_out,
    output logic        exec_strobe,
    output logic        halted
);

    seq_state_t state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FETCH;
            pc_out      <= RESET_PC;
            ir_out      <= 16'h0000;
            exec_strobe <= 1'b0;
            halted      <= 1'b0;
        end else begin
            exec_strobe <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (en && instr_valid) begin
                        ir_out      <= instr_rdata;
                        exec_strobe <= 1'b1;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (ir_out == HALT_INSTR) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    pc_out <= takes_target(flag_type) ? dis_in : pc_out + 16'd1;
                    state  <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    // Request follows en combinationally in FETCH; reset_n gating keeps it low during reset.
    assign instr_req  = reset_n && en && (state == ST_FETCH);
    assign instr_addr = pc_out;
    assign flag_type  = ir_out[15:12];
    assign condition  = ir_out[11:8];
    assign imm_out    = {{8{ir_out[7]}}, ir_out[7:0]};

endmodule
